// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared pipeline field layout, writeback encodings and MEM FSM states
package cpu_pipe_pkg;

  localparam int XLEN    = 32;
  localparam int REG_W   = 5;
  localparam int EXMEM_W = 106;
  localparam int MEMWB_W = 38;

  localparam int EXM_SDATA_LSB = 0;
  localparam int EXM_ALU_LSB   = 32;
  localparam int EXM_DEST_LSB  = 64;
  localparam int EXM_MEMREAD   = 69;
  localparam int EXM_MEMWRITE  = 70;
  localparam int EXM_REGWRITE  = 71;
  localparam int EXM_MTR_LSB   = 72;
  localparam int EXM_PC4_LSB   = 74;

  localparam int MWB_DATA_LSB = 0;
  localparam int MWB_DEST_LSB = 32;
  localparam int MWB_REGWRITE = 37;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Encoding 11 is not assigned and falls back to the ALU result.
  function automatic logic [XLEN-1:0] wb_select(input logic [1:0] mtr,
                                                input logic [XLEN-1:0] alu,
                                                input logic [XLEN-1:0] mem,
                                                input logic [XLEN-1:0] pc4);
    logic [XLEN-1:0] sel;
    case (mtr)
      MEMTOREG_MEM: sel = mem;
      MEMTOREG_PC4: sel = pc4;
      default:      sel = alu;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - data-memory bus IDLE/WAIT FSM with timeout, request, stall and bus_err generation
module mem_bus_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op_i,
  input  logic misalign_i,
  input  logic ready_i,
  output logic req_o,
  output logic stall_o,
  output logic bus_err_o
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req;
  logic       timeout;

  // The request follows EX_MEM directly; upstream holds EX_MEM while WAIT is pending.
  assign req     = mem_op_i & ~misalign_i;
  assign timeout = (state_q == ST_WAIT) & req & ~ready_i & (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = 8'd0;
    if (state_q == ST_IDLE) begin
      if (req && !ready_i) state_d = ST_WAIT;
    end else begin
      cnt_d = cnt_q + 8'd1;
      if (!req || ready_i || timeout) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_o     = req;
  assign stall_o   = req & ~ready_i & ~timeout;
  assign bus_err_o = ~rst & (timeout | (mem_op_i & misalign_i));

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: bus access, writeback select, forwarding, MEM_WB; MEM_ALIGN_CHECK_EN enables misalignment abort
module mem_stage
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [EXMEM_W-1:0] EX_MEM,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               dmem_ready,
  output logic               mem_stall,
  output logic               bus_err,
  output logic               MEM_RegWrite,
  output logic [REG_W-1:0]   MEM_WriteRegister,
  output logic [XLEN-1:0]    MEM_RegWriteData,
  output logic [MEMWB_W-1:0] MEM_WB
);

  logic [XLEN-1:0]    alu_res, pc4, wb_data;
  logic [REG_W-1:0]   dest;
  logic [1:0]         mtr;
  logic               reg_write, mem_op, misalign;
  logic [MEMWB_W-1:0] mem_wb_q, mem_wb_d;

  assign alu_res   = EX_MEM[EXM_ALU_LSB +: XLEN];
  assign pc4       = EX_MEM[EXM_PC4_LSB +: XLEN];
  assign dest      = EX_MEM[EXM_DEST_LSB +: REG_W];
  assign mtr       = EX_MEM[EXM_MTR_LSB +: 2];
  assign reg_write = EX_MEM[EXM_REGWRITE];
  assign mem_op    = EX_MEM[EXM_MEMREAD] | EX_MEM[EXM_MEMWRITE];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = |alu_res[1:0];
`else
  assign misalign = 1'b0;
`endif

  mem_bus_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_ctrl (
    .clk       (clk),
    .rst       (rst),
    .mem_op_i  (mem_op),
    .misalign_i(misalign),
    .ready_i   (dmem_ready),
    .req_o     (dmem_req),
    .stall_o   (mem_stall),
    .bus_err_o (bus_err)
  );

  // MemWrite has priority when both control bits are set.
  assign dmem_we    = EX_MEM[EXM_MEMWRITE];
  assign dmem_addr  = alu_res;
  assign dmem_wdata = EX_MEM[EXM_SDATA_LSB +: XLEN];

  assign wb_data           = wb_select(mtr, alu_res, dmem_rdata, pc4);
  assign MEM_RegWrite      = reg_write & ~mem_stall;
  assign MEM_WriteRegister = dest;
  assign MEM_RegWriteData  = wb_data;

  // Stalled and aborted accesses both leave a bubble behind.
  always_comb begin
    mem_wb_d = {reg_write, dest, wb_data};
    if (mem_stall || bus_err) mem_wb_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_wb_q <= '0;
    else     mem_wb_q <= mem_wb_d;
  end

  assign MEM_WB = mem_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage
module tb_mem_stage;
  import cpu_pipe_pkg::*;

  typedef struct packed {
    logic [37:0] wb;
    logic [37:0] mask;
  } sb_t;

  localparam logic [37:0] FULL = {38{1'b1}};
  localparam logic [37:0] RW_ONLY = 38'h20_0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [105:0] EX_MEM;
  logic         dmem_req, dmem_we, dmem_ready, mem_stall, bus_err;
  logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata, MEM_RegWriteData;
  logic         MEM_RegWrite;
  logic [4:0]   MEM_WriteRegister;
  logic [37:0]  MEM_WB;

  int n_chk  = 0;
  int n_fail = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .EX_MEM           (EX_MEM),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_ready       (dmem_ready),
    .mem_stall        (mem_stall),
    .bus_err          (bus_err),
    .MEM_RegWrite     (MEM_RegWrite),
    .MEM_WriteRegister(MEM_WriteRegister),
    .MEM_RegWriteData (MEM_RegWriteData),
    .MEM_WB           (MEM_WB)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [105:0] mk(input logic [31:0] pc4, input logic [1:0] mtr,
                                      input logic rw, input logic mw, input logic mr,
                                      input logic [4:0] dest, input logic [31:0] alu,
                                      input logic [31:0] sd);
    return {pc4, mtr, rw, mw, mr, dest, alu, sd};
  endfunction

  function automatic logic [37:0] wbv(input logic rw, input logic [4:0] dest, input logic [31:0] d);
    return {rw, dest, d};
  endfunction

  task automatic pop_check();
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("mem_wb", 64'(MEM_WB & e.mask), 64'(e.wb & e.mask));
    end
  endtask

  // One cycle: compare last cycle's MEM_WB, drive new inputs, check combinational outputs.
  task automatic step(input logic r, input logic [105:0] ex, input logic rdy, input logic [31:0] rd,
                      input logic e_req, input logic e_stall, input logic e_err,
                      input logic [37:0] e_wb, input logic [37:0] e_mask);
    sb_t e;
    @(posedge clk);
    #1;
    pop_check();
    rst        = r;
    EX_MEM     = ex;
    dmem_ready = rdy;
    dmem_rdata = rd;
    #1;
    chk("dmem_req", 64'(dmem_req), 64'(e_req));
    chk("mem_stall", 64'(mem_stall), 64'(e_stall));
    chk("bus_err", 64'(bus_err), 64'(e_err));
    e.wb   = e_wb;
    e.mask = e_mask;
    sb.push_back(e);
  endtask

  initial begin
    logic [105:0] op;
    rst        = 1'b1;
    EX_MEM     = '0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;

    step(1, '0, 0, 0, 0, 0, 0, '0, FULL);
    step(1, '0, 0, 0, 0, 0, 0, '0, FULL);

    // ALU op, forwarded and written back after one cycle
    op = mk(32'h0, MEMTOREG_ALU, 1, 0, 0, 5'd5, 32'h1234, 32'h0);
    step(0, op, 0, 0, 0, 0, 0, wbv(1, 5'd5, 32'h1234), FULL);
    chk("fwd_data_alu", 64'(MEM_RegWriteData), 64'h1234);
    chk("fwd_rw_alu", 64'(MEM_RegWrite), 64'd1);
    chk("fwd_reg_alu", 64'(MEM_WriteRegister), 64'd5);

    // zero-wait load
    op = mk(32'h0, MEMTOREG_MEM, 1, 0, 1, 5'd7, 32'h100, 32'h0);
    step(0, op, 1, 32'hDEADBEEF, 1, 0, 0, wbv(1, 5'd7, 32'hDEADBEEF), FULL);
    chk("fwd_data_ld", 64'(MEM_RegWriteData), 64'hDEADBEEF);
    chk("dmem_we_ld", 64'(dmem_we), 64'd0);

    // store with three wait cycles: bus signals must stay stable throughout
    op = mk(32'h0, MEMTOREG_ALU, 0, 1, 0, 5'd3, 32'h40, 32'hA5A5A5A5);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        step(0, op, 0, 0, 1, 1, 0, '0, FULL);
        chk("fwd_rw_stall", 64'(MEM_RegWrite), 64'd0);
      end else begin
        step(0, op, 1, 32'hFFFF0000, 1, 0, 0, wbv(0, 5'd3, 32'h40), FULL);
      end
      chk("st_addr", 64'(dmem_addr), 64'h40);
      chk("st_wdata", 64'(dmem_wdata), 64'hA5A5A5A5);
      chk("st_we", 64'(dmem_we), 64'd1);
    end

    // load that never completes: abort on the fourth WAIT cycle
    op = mk(32'h0, MEMTOREG_MEM, 1, 0, 1, 5'd9, 32'h200, 32'h0);
    for (int i = 0; i < 4; i++) step(0, op, 0, 0, 1, 1, 0, '0, FULL);
    step(0, op, 0, 32'h55555555, 1, 0, 1, '0, RW_ONLY);
    step(0, '0, 0, 0, 0, 0, 0, '0, FULL);

    // reset in the middle of WAIT, then a normal one-wait load
    op = mk(32'h0, MEMTOREG_MEM, 1, 0, 1, 5'd12, 32'h300, 32'h0);
    step(0, op, 0, 0, 1, 1, 0, '0, FULL);
    step(0, op, 0, 0, 1, 1, 0, '0, FULL);
    step(1, '0, 0, 0, 0, 0, 0, '0, FULL);
    step(0, op, 0, 0, 1, 1, 0, '0, FULL);
    step(0, op, 1, 32'h0BADF00D, 1, 0, 0, wbv(1, 5'd12, 32'h0BADF00D), FULL);

    // PC+4 writeback to $31, MemtoReg=11 falls back to ALU, read+write treated as store
    op = mk(32'h00400008, MEMTOREG_PC4, 1, 0, 0, 5'd31, 32'hFFFF, 32'h0);
    step(0, op, 0, 0, 0, 0, 0, wbv(1, 5'd31, 32'h00400008), FULL);
    op = mk(32'h00400008, 2'b11, 1, 0, 0, 5'd0, 32'hCAFE, 32'h0);
    step(0, op, 1, 32'h1111, 0, 0, 0, wbv(1, 5'd0, 32'hCAFE), FULL);
    op = mk(32'h0, MEMTOREG_ALU, 0, 1, 1, 5'd2, 32'h80, 32'h55);
    step(0, op, 1, 0, 1, 0, 0, wbv(0, 5'd2, 32'h80), FULL);
    chk("rw_both_we", 64'(dmem_we), 64'd1);

    // misaligned load
    op = mk(32'h0, MEMTOREG_MEM, 1, 0, 1, 5'd4, 32'h102, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    step(0, op, 0, 32'h13572468, 0, 0, 1, '0, FULL);
`else
    step(0, op, 1, 32'h13572468, 1, 0, 0, wbv(1, 5'd4, 32'h13572468), FULL);
    chk("misalign_addr", 64'(dmem_addr), 64'h102);
`endif

    step(0, '0, 0, 0, 0, 0, 0, '0, FULL);
    @(posedge clk);
    #1;
    pop_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
